mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_if.sv | 25 ++
 rtl/mult_div_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mult_div_unit_if.sv
// Operand/result bundle for mult_div_unit: start strobes and operands in,
// results and status out.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             mult_start;
  logic             div_start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output mult_start, div_start, a, b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  mult_start, div_start, a, b,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on magnitudes),
// one iteration per clock, WIDTH iterations per operation.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus,
  output logic [1:0]      state_o
);
  // Handshake: a start strobe is taken on the rising edge only while idle or
  // done (multiply wins if both are high); done is a one-cycle pulse after the
  // final iteration, and hi/lo/div_zero are valid from that cycle until the next start.
  typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] qr_q, qr_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic             qm1_q, qm1_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic [WIDTH:0]   booth_sum, mul_acc_n, div_r, div_t, div_acc_n;
  logic [WIDTH-1:0] mul_qr_n, div_qr_n, a_mag, b_mag;
  logic             last_iter;

  // One Booth step and one restoring-division step, evaluated every cycle.
  always_comb begin
    case ({qr_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + {m_q[WIDTH-1], m_q};
      2'b10:   booth_sum = acc_q - {m_q[WIDTH-1], m_q};
      default: booth_sum = acc_q;
    endcase
    mul_acc_n = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mul_qr_n  = {booth_sum[0], qr_q[WIDTH-1:1]};
    div_r     = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
    div_t     = div_r - {1'b0, m_q};
    if (div_t[WIDTH]) begin
      div_acc_n = div_r;
      div_qr_n  = {qr_q[WIDTH-2:0], 1'b0};
    end else begin
      div_acc_n = div_t;
      div_qr_n  = {qr_q[WIDTH-2:0], 1'b1};
    end
    a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
    b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    qr_d      = qr_q;
    m_d       = m_q;
    qm1_d     = qm1_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    last_iter = (cnt_q == CW'(1));
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (bus.mult_start) begin
          state_d = MULT;
          cnt_d   = CW'(WIDTH);
          dz_d    = 1'b0;
          acc_d   = '0;
          qr_d    = bus.a;
          m_d     = bus.b;
          qm1_d   = 1'b0;
        end else if (bus.div_start) begin
          cnt_d  = CW'(WIDTH);
          acc_d  = '0;
          qr_d   = a_mag;
          m_d    = b_mag;
          qneg_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          rneg_d = bus.a[WIDTH-1];
          // A zero divisor finishes immediately and leaves hi/lo untouched.
          if (bus.b == '0) begin
            state_d = DONE;
            dz_d    = 1'b1;
          end else begin
            state_d = DIV;
            dz_d    = 1'b0;
          end
        end
      end
      MULT: begin
        cnt_d = cnt_q - 1'b1;
        acc_d = mul_acc_n;
        qr_d  = mul_qr_n;
        qm1_d = qr_q[0];
        if (last_iter) begin
          hi_d    = mul_acc_n[WIDTH-1:0];
          lo_d    = mul_qr_n;
          state_d = DONE;
        end
      end
      DIV: begin
        cnt_d = cnt_q - 1'b1;
        acc_d = div_acc_n;
        qr_d  = div_qr_n;
        if (last_iter) begin
          lo_d    = qneg_q ? -div_qr_n : div_qr_n;
          hi_d    = rneg_q ? -div_acc_n[WIDTH-1:0] : div_acc_n[WIDTH-1:0];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      qr_q    <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      qr_q    <= qr_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = (state_q == MULT) || (state_q == DIV);
  assign bus.done     = (state_q == DONE);
  assign bus.div_zero = dz_q;
  assign state_o      = state_q;
endmodule
